// File: rtl/ram_port_initiator.sv
// ---------------------------------------------------------------------------
// ram_port_initiator
//
// Front end for a single-port RAM with a one-cycle read latency.
//
// After reset the block can optionally zero-fill the whole RAM (CLEAR).
// It then passes a valid/ready command stream straight onto the RAM port
// (RUN). Read data comes back through a response channel with its own
// valid/ready handshake.
//
// Read data is either forwarded directly from the RAM (bypass) or parked in
// a two-entry FIFO when the consumer stalls. Command acceptance is throttled
// so the number of outstanding reads never exceeds the FIFO capacity. This
// keeps the response path lossless without needing to stall the RAM.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  command handshake
//   req_write_i          1 = write, 0 = read
//   req_addr_i           word address (AW bits)
//   req_wdata_i          write data (Width bits)
//   req_wmask_i          per-lane write enables (MW bits)
//   rsp_valid_o/ready_i  read response handshake
//   rsp_rdata_o          read response data
//   ram_req_o            RAM access strobe
//   ram_write_o          RAM write strobe
//   ram_addr_o           RAM address
//   ram_wdata_o          RAM write data
//   ram_wmask_o          RAM lane write enables
//   ram_rdata_i          RAM read data, valid one cycle after a read
//   init_done_o          high once the RAM is ready for commands
// ---------------------------------------------------------------------------
module ram_port_initiator #(
    parameter int unsigned Width           = 32,
    parameter int unsigned Depth           = 1024,
    parameter int unsigned DataBitsPerMask = 8,
    parameter bit          ClearOnReset    = 1'b1,
    // Derived widths; Width must be a whole number of mask lanes.
    localparam int unsigned AW             = $clog2(Depth),
    localparam int unsigned MW             = Width / DataBitsPerMask
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [MW-1:0]    req_wmask_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,

    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [AW-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [MW-1:0]    ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,

    output logic             init_done_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [AW-1:0]    clr_cnt_q,    clr_cnt_d;
    logic             inflight_q,   inflight_d;
    logic [1:0]       fifo_count_q, fifo_count_d;
    logic             wr_ptr_q,     wr_ptr_d;
    logic             rd_ptr_q,     rd_ptr_d;
    logic [Width-1:0] fifo_mem_q [2];
    logic [Width-1:0] fifo_mem_d [2];

    // ------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------
    logic       run;
    logic [1:0] occupancy;
    logic       req_fire;
    logic       rd_fire;
    logic       fifo_empty;
    logic       pop;
    logic       pop_fifo;
    logic       push;

    // The reset input gates the outward strobes. This keeps them quiet for
    // the whole time reset is held, whatever state the FSM resets into.
    assign run        = rst_ni && (state_q == ST_RUN);
    assign occupancy  = {1'b0, inflight_q} + fifo_count_q;
    assign req_ready_o = run && (occupancy < 2'd2);
    assign req_fire   = req_valid_i && req_ready_o;
    assign rd_fire    = req_fire && !req_write_i;
    assign init_done_o = run;

    assign fifo_empty  = (fifo_count_q == 2'd0);
    assign rsp_valid_o = inflight_q || !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign pop_fifo    = pop && !fifo_empty;
    // Returning RAM data is parked unless the consumer takes it straight
    // off the bypass. That is only possible when nothing older is queued.
    assign push        = inflight_q && !(pop && fifo_empty);

    // Older queued data always wins over the bypass, which keeps order.
    // With nothing outstanding the output is held at zero, so the RAM's
    // idle read bus never leaks out.
    always_comb begin
        rsp_rdata_o = '0;
        if (!fifo_empty) begin
            rsp_rdata_o = fifo_mem_q[rd_ptr_q];
        end else if (inflight_q) begin
            rsp_rdata_o = ram_rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux: the clear engine owns the port in CLEAR; in RUN the
    // command passes through with no added latency.
    // ------------------------------------------------------------------
    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (state_q == ST_CLEAR) begin
            ram_req_o   = rst_ni;
            ram_write_o = 1'b1;
            ram_addr_o  = clr_cnt_q;
            ram_wdata_o = '0;
            ram_wmask_o = '1;
        end else begin
            ram_req_o   = req_fire;
            ram_write_o = req_write_i;
            ram_addr_o  = req_addr_i;
            ram_wdata_o = req_wdata_i;
            ram_wmask_o = req_wmask_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            // The edge that writes the last word also hands over to RUN.
            if (clr_cnt_q == LastAddr) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    always_comb begin
        // A read is in flight for exactly the cycle after its acceptance.
        inflight_d   = rd_fire;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop_fifo;
        fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, pop_fifo};
        fifo_mem_d   = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = ram_rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ClearOnReset ? ST_CLEAR : ST_RUN;
            clr_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            fifo_count_q <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fifo_mem_q[gi] <= '0;
            end else begin
                fifo_mem_q[gi] <= fifo_mem_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_ram_port_initiator.sv
`define CHK(TAG, OBS, EXP) \
    begin \
        n_checks++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
        end \
    end

module tb_ram_port_initiator;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int MW = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [W-1:0]  req_wdata_i;
    logic [MW-1:0] req_wmask_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [W-1:0]  rsp_rdata_o;
    logic          ram_req_o, ram_write_o;
    logic [AW-1:0] ram_addr_o;
    logic [W-1:0]  ram_wdata_o;
    logic [MW-1:0] ram_wmask_o;
    logic [W-1:0]  ram_rdata_i;
    logic          init_done_o;

    always #5 clk = ~clk;

    ram_port_initiator #(
        .Width(W), .Depth(D), .DataBitsPerMask(8), .ClearOnReset(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i),
        .init_done_o(init_done_o)
    );

    logic [W-1:0] env_mem [D];
    logic [W-1:0] env_tmp;
    always @(posedge clk) begin
        if (ram_req_o && ram_write_o) begin
            env_tmp = env_mem[ram_addr_o];
            for (int k = 0; k < MW; k++)
                if (ram_wmask_o[k]) env_tmp[k*8 +: 8] = ram_wdata_o[k*8 +: 8];
            env_mem[ram_addr_o] <= env_tmp;
            ram_rdata_i <= $urandom;
        end else if (ram_req_o) begin
            ram_rdata_i <= env_mem[ram_addr_o];
        end else begin
            ram_rdata_i <= $urandom;
        end
    end

    logic [W-1:0] ref_mem [D];
    logic [W-1:0] exp_q [$];
    int           clr_edges;
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           last_acc;
    int           last_wait;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_w,
                                           input logic [W-1:0] new_w,
                                           input logic [MW-1:0] m);
        logic [W-1:0] r;
        r = old_w;
        for (int k = 0; k < MW; k++)
            if (m[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        bit exp_rdy, exp_vld, exp_done, acc, pop;
        @(negedge clk);
        exp_done = (clr_edges >= D);
        exp_rdy  = exp_done && (exp_q.size() < 2);
        exp_vld  = (exp_q.size() > 0);
        `CHK("init_done", init_done_o, exp_done)
        `CHK("req_ready", req_ready_o, exp_rdy)
        `CHK("rsp_valid", rsp_valid_o, exp_vld)
        if (exp_vld) `CHK("rsp_data", rsp_rdata_o, exp_q[0])
        if (!exp_done) begin
            `CHK("clear_req",   ram_req_o,   1'b1)
            `CHK("clear_write", ram_write_o, 1'b1)
            `CHK("clear_addr",  ram_addr_o,  AW'(clr_edges))
            `CHK("clear_wdata", ram_wdata_o, 32'h0)
            `CHK("clear_mask",  ram_wmask_o, 4'hF)
        end else begin
            `CHK("run_req", ram_req_o, req_valid_i && exp_rdy)
            if (req_valid_i && exp_rdy) begin
                `CHK("run_write", ram_write_o, req_write_i)
                `CHK("run_addr",  ram_addr_o,  req_addr_i)
                if (req_write_i) begin
                    `CHK("run_wdata", ram_wdata_o, req_wdata_i)
                    `CHK("run_wmask", ram_wmask_o, req_wmask_i)
                end
            end
        end
        acc = req_valid_i && exp_rdy;
        pop = exp_vld && rsp_ready_i;
        @(posedge clk);
        if (!exp_done) clr_edges++;
        if (pop) begin
            $display("%0t rsp  data=%08h", $time, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            if (req_write_i) begin
                ref_mem[req_addr_i] = merge(ref_mem[req_addr_i], req_wdata_i, req_wmask_i);
                $display("%0t wr   addr=%0d data=%08h mask=%h", $time, req_addr_i, req_wdata_i, req_wmask_i);
            end else begin
                exp_q.push_back(ref_mem[req_addr_i]);
                $display("%0t rd   addr=%0d", $time, req_addr_i);
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input bit wr, input logic [AW-1:0] a,
                        input logic [W-1:0] wd, input logic [MW-1:0] m);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_wmask_i = m;
        last_acc    = 1'b0;
        last_wait   = 0;
        for (int i = 0; i < 20 && !last_acc; i++) begin
            tick();
            last_wait++;
        end
        `CHK("send_accepted", last_acc, 1'b1)
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        `CHK("drain_empty", exp_q.size(), 0)
    endtask

    task automatic do_reset();
        req_valid_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        `CHK("rst_req_ready",  req_ready_o, 1'b0)
        `CHK("rst_rsp_valid",  rsp_valid_o, 1'b0)
        `CHK("rst_ram_req",    ram_req_o,   1'b0)
        `CHK("rst_init_done",  init_done_o, 1'b0)
        `CHK("rst_rsp_rdata",  rsp_rdata_o, 32'h0)
        clr_edges = 0;
        exp_q.delete();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic run_clear(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid_i = 1'($urandom);
            req_write_i = 1'($urandom);
            req_addr_i  = AW'($urandom);
            req_wdata_i = $urandom;
            req_wmask_i = MW'($urandom);
            rsp_ready_i = 1'($urandom);
            tick();
        end
        req_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wmask_i = '0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < D; i++) env_mem[i] = $urandom | 32'h1;

        do_reset();
        run_clear(D - 1);
        n_checks++;
        if (init_done_o !== 1'b0) begin
            n_fail++;
            $error("FAIL clear_not_done_1023 observed=%0h expected=0", init_done_o);
        end
        run_clear(1);
        n_checks++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $error("FAIL clear_done_1024 observed=%0h expected=1", init_done_o);
        end
        n_checks++;
        if (env_mem[0] !== 32'h0) begin
            n_fail++;
            $error("FAIL clear_mem0 observed=%0h expected=0", env_mem[0]);
        end
        n_checks++;
        if (env_mem[300] !== 32'h0) begin
            n_fail++;
            $error("FAIL clear_mem300 observed=%0h expected=0", env_mem[300]);
        end
        n_checks++;
        if (env_mem[1023] !== 32'h0) begin
            n_fail++;
            $error("FAIL clear_mem1023 observed=%0h expected=0", env_mem[1023]);
        end

        rsp_ready_i = 1'b1;
        send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        send(1'b0, 10'd5, 32'h0, 4'h0);
        n_checks++;
        if (rsp_valid_o !== 1'b1) begin
            n_fail++;
            $error("FAIL wr_rd_valid observed=%0h expected=1", rsp_valid_o);
        end
        n_checks++;
        if (rsp_rdata_o !== 32'hDEADBEEF) begin
            n_fail++;
            $error("FAIL wr_rd_data observed=%0h expected=deadbeef", rsp_rdata_o);
        end
        tick();

        send(1'b1, 10'd7, 32'h11223344, 4'b0101);
        send(1'b0, 10'd7, 32'h0, 4'h0);
        n_checks++;
        if (rsp_rdata_o !== 32'h00220044) begin
            n_fail++;
            $error("FAIL partial_data observed=%0h expected=00220044", rsp_rdata_o);
        end
        tick();

        send(1'b1, 10'd9, 32'hCAFEF00D, 4'hF);
        rsp_ready_i = 1'b0;
        send(1'b0, 10'd5, 32'h0, 4'h0);
        send(1'b0, 10'd7, 32'h0, 4'h0);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 10'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (last_acc !== 1'b0) begin
                n_fail++;
                $error("FAIL bp_third_blocked observed=%0h expected=0", last_acc);
            end
        end
        n_checks++;
        if (req_ready_o !== 1'b0) begin
            n_fail++;
            $error("FAIL bp_ready_low observed=%0h expected=0", req_ready_o);
        end
        rsp_ready_i = 1'b1;
        send(1'b0, 10'd9, 32'h0, 4'h0);
        drain();

        for (int i = 0; i < 8; i++) begin
            send(1'b0, AW'(5 + (i % 5)), 32'h0, 4'h0);
            if (i > 0) begin
                n_checks++;
                if (last_wait !== 1) begin
                    n_fail++;
                    $error("FAIL stream_one_per_cycle observed=%0d expected=1", last_wait);
                end
            end
        end
        drain();

        for (int i = 0; i < 400; i++) begin
            req_valid_i = 1'($urandom);
            req_write_i = 1'($urandom);
            req_addr_i  = AW'($urandom_range(0, 15));
            req_wdata_i = $urandom;
            req_wmask_i = MW'($urandom);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        rsp_ready_i = 1'b0;
        send(1'b0, 10'd9, 32'h0, 4'h0);
        do_reset();
        run_clear(300);
        n_checks++;
        if (ram_addr_o !== 10'd300) begin
            n_fail++;
            $error("FAIL clear_restart_at_300 observed=%0d expected=300", ram_addr_o);
        end

        do_reset();
        run_clear(D);
        n_checks++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $error("FAIL reclear_done observed=%0h expected=1", init_done_o);
        end
        rsp_ready_i = 1'b1;
        send(1'b0, 10'd9, 32'h0, 4'h0);
        n_checks++;
        if (rsp_rdata_o !== 32'h0) begin
            n_fail++;
            $error("FAIL reclear_read_zero observed=%0h expected=0", rsp_rdata_o);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
